mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; results commit after 32 steps.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [1:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] mag_b_r;
    logic [31:0] w_hi_r;
    logic [31:0] w_lo_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic [32:0] sum_s;
    logic [32:0] shifted_s;
    logic [31:0] diff_s;
    logic        ge_s;
    logic [31:0] step_hi_s;
    logic [31:0] step_lo_s;
    logic        is_signed_s;
    logic [63:0] prod_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
        if (is_signed && x[31]) begin
            magnitude = ~x + 32'd1;
        end else begin
            magnitude = x;
        end
    endfunction

    // One iteration of the datapath; w_lo holds multiplier or dividend/quotient bits.
    always_comb begin
        sum_s     = {1'b0, w_hi_r} + (w_lo_r[0] ? {1'b0, mag_b_r} : 33'd0);
        shifted_s = {w_hi_r, w_lo_r[31]};
        ge_s      = (shifted_s >= {1'b0, mag_b_r});
        diff_s    = shifted_s[31:0] - mag_b_r;
        if (op_r[1]) begin
            step_hi_s = ge_s ? diff_s : shifted_s[31:0];
            step_lo_s = {w_lo_r[30:0], ge_s};
        end else begin
            step_hi_s = sum_s[32:1];
            step_lo_s = {sum_s[0], w_lo_r[31:1]};
        end
    end

    // Sign correction of the final step; quotient sign from both operands, remainder from dividend.
    always_comb begin
        is_signed_s = ~op_r[0];
        prod_s      = {step_hi_s, step_lo_s};
        res_hi_s    = step_hi_s;
        res_lo_s    = step_lo_s;
        if (!op_r[1]) begin
            if (is_signed_s && (a_r[31] ^ b_r[31])) begin
                prod_s = ~prod_s + 64'd1;
            end else begin
                prod_s = prod_s;
            end
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end else if (b_r == 32'd0) begin
            res_hi_s = a_r;
            res_lo_s = 32'hFFFF_FFFF;
        end else begin
            res_lo_s = (is_signed_s && (a_r[31] ^ b_r[31])) ? (~step_lo_s + 32'd1) : step_lo_s;
            res_hi_s = (is_signed_s && a_r[31]) ? (~step_hi_s + 32'd1) : step_hi_s;
        end
    end

    // Control FSM, operand latches, working registers and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            op_r    <= 2'b00;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            mag_b_r <= 32'd0;
            w_hi_r  <= 32'd0;
            w_lo_r  <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        a_r     <= a;
                        b_r     <= b;
                        mag_b_r <= magnitude(b, ~op[0]);
                        w_hi_r  <= 32'd0;
                        w_lo_r  <= magnitude(a, ~op[0]);
                        cnt_r   <= 5'd0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        if (mthi) hi_r <= wdata;
                        if (mtlo) lo_r <= wdata;
                    end
                end
                RUN: begin
                    w_hi_r <= step_hi_s;
                    w_lo_r <= step_lo_s;
                    cnt_r  <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        hi_r    <= res_hi_s;
                        lo_r    <= res_lo_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule
